instr_encoder_loader: RTL and testbench

- Inverse of the core's instruction decoder. Accepts decoded RV32I instruction descriptors (class, registers, funct3, alt bit, 32-bit immediate) over a valid/ready stream.
- Packs each descriptor into a 32-bit instruction word with the same field layout the decoder extracts.
- Writes words sequentially into instruction memory through a write port.
- Used by the testbench/boot path to load programs without a precompiled hex image.

---
 rtl/encoder_pkg.sv | 44 ++++
 rtl/instr_pack.sv | 61 ++++++
 rtl/instr_encoder_loader.sv | 136 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the instruction encoder/loader: instruction classes,
// RV32I opcodes (same values the decoder matches), the NOP word, the loader
// FSM states and an immediate range helper.
package encoder_pkg;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_IALU   = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } instr_class_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    // True when v, read as a signed value, fits in a bits-wide two's complement field.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (bits - 1);
        return ($signed(v) >= -lim) && ($signed(v) < lim);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational descriptor -> RV32I instruction word packer.
// With ENCODER_RANGE_CHECK_EN defined, range_err flags immediates that do not
// fit their field and unknown classes; otherwise range_err is tied low and
// out-of-range immediates are silently truncated.
module instr_pack
    import encoder_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_err
);

    logic is_shift;
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Place each field where the decoder extracts it; unused fields stay zero.
    always_comb begin
        word = NOP;
        case (cls)
            CLS_R:      word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OPC_R};
            CLS_IALU:   word = is_shift ? {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OPC_IALU}
                                        : {imm[11:0], rs1, funct3, rd, OPC_IALU};
            CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            CLS_LUI:    word = {imm[31:12], rd, OPC_LUI};
            CLS_AUIPC:  word = {imm[31:12], rd, OPC_AUIPC};
            CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            default:    word = NOP;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // Flag immediates that the packed field cannot represent exactly.
    always_comb begin
        range_err = 1'b0;
        case (cls)
            CLS_R:      range_err = 1'b0;
            CLS_IALU:   range_err = is_shift ? (imm[31:5] != '0) : !fits_signed(imm, 12);
            CLS_LOAD,
            CLS_STORE,
            CLS_JALR:   range_err = !fits_signed(imm, 12);
            CLS_BRANCH: range_err = !fits_signed(imm, 13) || imm[0];
            CLS_JAL:    range_err = !fits_signed(imm, 21) || imm[0];
            CLS_LUI,
            CLS_AUIPC:  range_err = (imm[11:0] != 12'd0);
            default:    range_err = 1'b1;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts decoded RV32I descriptors on a
// valid/ready stream, packs them into instruction words and writes them to
// consecutive instruction-memory addresses starting at BASE_ADDR.
// Optional immediate range checking is enabled by ENCODER_RANGE_CHECK_EN.
//
// Handshake: a descriptor transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready does not depend on in_valid, and the
// source holds its fields stable while in_valid is high and in_ready is low.
module instr_encoder_loader
    import encoder_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W+1:0] DEPTH_W  = (ADDR_W + 2)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    enc_state_e        state, state_n;
    logic [ADDR_W-1:0] ptr;
    logic              pend;
    logic [31:0]       pend_word;
    logic              pend_last;
    logic              pend_rerr;
    logic [31:0]       word;
    logic              range_err;
    logic              accept;
    logic              write_end;
    logic [ADDR_W+1:0] fill;

    instr_pack u_pack (
        .cls       (in_class),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .alt       (in_alt),
        .imm       (in_imm),
        .word      (word),
        .range_err (range_err)
    );

    // Words written plus the one waiting to be written bound further accepts.
    assign fill      = {1'b0, count} + {{(ADDR_W + 1){1'b0}}, pend};
    assign accept    = in_valid && in_ready;
    // The session ends with the write of a last descriptor or the one that fills memory.
    assign write_end = pend && (pend_last || (count == LAST_CNT));

    assign mem_we    = pend;
    assign mem_addr  = ptr;
    assign mem_wdata = pend ? pend_word : 32'd0;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next state and handshake/status outputs.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                busy     = 1'b1;
                in_ready = !(pend && pend_last) && (fill < DEPTH_W);
                if (write_end) state_n = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Write pointer, counters, error flag and the one-deep write register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= BASE_PTR;
            count     <= '0;
            err       <= 1'b0;
            pend      <= 1'b0;
            pend_word <= 32'd0;
            pend_last <= 1'b0;
            pend_rerr <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                ptr   <= BASE_PTR;
                count <= '0;
                err   <= 1'b0;
            end
            if (pend) begin
                ptr   <= ptr + 1'b1;
                count <= count + 1'b1;
                if (pend_rerr || (count == LAST_CNT && !pend_last)) err <= 1'b1;
            end
            pend <= accept;
            if (accept) begin
                pend_word <= word;
                pend_last <= in_last;
                pend_rerr <= range_err;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader with a 4-word memory (ADDR_W = 2).
// Expected words are hand-encoded constants; the scoreboard queues the
// expected address/word at each accept and the write monitor pops them.
module tb_instr_encoder_loader;
    import encoder_pkg::*;

    localparam int AW = 2;
`ifdef ENCODER_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_class = 4'd0;
    logic [4:0]    in_rd = 5'd0;
    logic [4:0]    in_rs1 = 5'd0;
    logic [4:0]    in_rs2 = 5'd0;
    logic [2:0]    in_funct3 = 3'd0;
    logic          in_alt = 1'b0;
    logic [31:0]   in_imm = 32'd0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = 0;
    logic [31:0]   exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] exp_addr = '0;

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .err       (err)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Write monitor: every memory write must match the oldest expected entry.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(mem_we), 32'd0);
            end else begin
                check("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                check("wr_data", mem_wdata, exp_q.pop_front());
            end
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
        end
    end

    // Called at a falling edge; returns at a falling edge with the FSM in LOAD.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = '0;
    endtask

    // Present one descriptor until accepted; queue its expected write.
    task automatic send(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [31:0] imm, input logic last, input logic [31:0] w);
        logic acc;
        acc = 1'b0;
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_alt = alt; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back(w);
                exp_addr_q.push_back(exp_addr);
                exp_addr++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 20; t++) begin
            if (done) break;
            @(negedge clk);
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // addi x1, x0, 5 as a single-word session
        do_start();
        send(CLS_IALU, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b1, 32'h0050_0093);
        @(negedge clk);
        check("t1_done", 32'(done), 32'd1);
        check("t1_count", 32'(count), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // sub x3,x1,x2 then beq x1,x2,-4 back to back
        do_start();
        send(CLS_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 1'b0, 32'h4020_81B3);
        send(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
        @(negedge clk);
        check("t2_done", 32'(done), 32'd1);
        check("t2_count", 32'(count), 32'd2);
        check("t2_b2b", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);
        @(negedge clk);

        // jal x1,8; srai x5,x5,3; slli x5,x5,3
        do_start();
        send(CLS_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8, 1'b0, 32'h0080_00EF);
        send(CLS_IALU, 5'd5, 5'd5, 5'd0, 3'b101, 1'b1, 32'd3, 1'b0, 32'h4032_D293);
        send(CLS_IALU, 5'd5, 5'd5, 5'd0, 3'b001, 1'b0, 32'd3, 1'b1, 32'h0032_9293);
        wait_done("t3_done");
        check("t3_err", 32'(err), 32'd0);
        check("t3_count", 32'(count), 32'd3);
        @(negedge clk);

        // lui x2; sw x2,-8(x1); jalr x1,4(x2) with funct3 forced to 000
        do_start();
        send(CLS_LUI, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000, 1'b0, 32'h1234_5137);
        send(CLS_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'hFE20_AC23);
        send(CLS_JALR, 5'd1, 5'd2, 5'd0, 3'b111, 1'b0, 32'd4, 1'b1, 32'h0041_00E7);
        wait_done("t4_done");
        check("t4_err", 32'(err), 32'd0);
        check("t4_count", 32'(count), 32'd3);
        @(negedge clk);

        // Overflow: four descriptors fill memory, the fifth is refused
        do_start();
        send(CLS_IALU, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 1'b0, 32'h0010_0093);
        send(CLS_IALU, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 1'b0, 32'h0020_0093);
        send(CLS_IALU, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3, 1'b0, 32'h0030_0093);
        send(CLS_IALU, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4, 1'b0, 32'h0040_0093);
        in_imm = 32'd5; in_valid = 1'b1;
        check("ovf_ready_after_4", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_ready_done", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ovf_ready_idle", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        // Unknown class writes a NOP; flagged only with range checking
        do_start();
        check("unk_err_cleared", 32'(err), 32'd0);
        send(4'd9, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'd0, 1'b1, NOP);
        wait_done("unk_done");
        check("unk_err", 32'(err), 32'(RC));
        @(negedge clk);

        // addi imm=2048 truncates to 0x800
        do_start();
        send(CLS_IALU, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 1'b1, 32'h8000_0013);
        wait_done("rng_done");
        check("rng_err", 32'(err), 32'(RC));
        @(negedge clk);

        // Reset mid-session with a write pending
        do_start();
        send(CLS_IALU, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 1'b0, 32'h0010_0093);
        in_class = CLS_IALU; in_rd = 5'd2; in_imm = 32'd9; in_valid = 1'b1;
        check("mid_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_we", 32'(mem_we), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_count", 32'(count), 32'd0);
        check("mid_ready_rst", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        send(CLS_IALU, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 1'b1, 32'h0020_0113);
        wait_done("post_rst_done");
        check("post_rst_count", 32'(count), 32'd1);
        @(negedge clk);

        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
